// File: rtl/ofdm_pkg.sv
// ----------------------------------------------------------------------------
// ofdm_pkg
// Shared types and default constants for the OFDM hard-decision bit packer.
//   mode_e  : modulation of a symbol (BPSK = 1 bit/bin, QPSK = 2 bits/bin)
//   state_e : packer FSM states
//   *_DEF   : default parameter values used by the packer and slicer
// ----------------------------------------------------------------------------
package ofdm_pkg;

    typedef enum logic {
        MODE_BPSK = 1'b0,
        MODE_QPSK = 1'b1
    } mode_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    localparam int DIN_W_DEF  = 17;
    localparam int NBINS_DEF  = 128;
    localparam int DOUT_W_DEF = 48;

endpackage : ofdm_pkg

// File: rtl/ofdm_slicer.sv
// ----------------------------------------------------------------------------
// ofdm_slicer
// Purely combinational hard-decision slicer for one frequency bin.
// Ports:
//   i_din_r  : signed real component
//   i_din_i  : signed imaginary component
//   i_mode   : BPSK slices the real part only, QPSK slices both
//   o_bits   : decision bits, real part in bit 0, imaginary part in bit 1
//              (bit 1 is always 0 in BPSK)
//   o_nbits  : number of valid decision bits (1 or 2)
// ----------------------------------------------------------------------------
module ofdm_slicer
    import ofdm_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF
) (
    input  logic signed [DIN_W-1:0] i_din_r,
    input  logic signed [DIN_W-1:0] i_din_i,
    input  mode_e                   i_mode,
    output logic        [1:0]       o_bits,
    output logic        [1:0]       o_nbits
);

    // Only the sign decides a hard bit; the magnitude bits are deliberately
    // folded into a sink so their disuse is visible and intentional.
    logic w_unused_mag;
    assign w_unused_mag = ^{i_din_r[DIN_W-2:0], i_din_i[DIN_W-2:0]};

    // NOTE: every output gets a default at the top of the block, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        o_bits  = {1'b0, i_din_r[DIN_W-1]};
        o_nbits = 2'd1;
        if (i_mode == MODE_QPSK) begin
            o_bits  = {i_din_i[DIN_W-1], i_din_r[DIN_W-1]};
            o_nbits = 2'd2;
        end
    end

endmodule : ofdm_slicer

// File: rtl/ofdm_bit_packer.sv
// ----------------------------------------------------------------------------
// ofdm_bit_packer
// Collects NBINS frequency bins per OFDM symbol, slices each to 1 (BPSK) or
// 2 (QPSK) hard bits and packs them LSB-first into DOUT_W-bit words. A word
// is emitted as soon as it fills; the last bin of a symbol flushes the
// partial word (zero-padded) with LastOut set.
// Ports:
//   Clk, Reset          : clock, asynchronous active-high reset
//   Pushin, FirstData   : bin valid, bin-0 marker (qualified by Pushin)
//   DinR, DinI          : signed bin components
//   Mode                : 0 = BPSK, 1 = QPSK, sampled with FirstData only
//   PushOut, DataOut    : one-cycle word strobe, packed word (held when idle)
//   LastOut             : word is the final one of its symbol
//   SymErr              : one-cycle framing-error pulse
//   SymCount            : completed symbols, wraps at 16 bits
// ----------------------------------------------------------------------------
module ofdm_bit_packer
    import ofdm_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int NBINS  = NBINS_DEF,
    parameter int DOUT_W = DOUT_W_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Pushin,
    input  logic                    FirstData,
    input  logic signed [DIN_W-1:0] DinR,
    input  logic signed [DIN_W-1:0] DinI,
    input  logic                    Mode,
    output logic                    PushOut,
    output logic        [DOUT_W-1:0] DataOut,
    output logic                    LastOut,
    output logic                    SymErr,
    output logic        [15:0]      SymCount
);

    localparam int BIN_W = $clog2(NBINS);
    localparam int PTR_W = $clog2(DOUT_W + 1);
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NBINS - 1);
    localparam logic [PTR_W-1:0] FULL_PTR = PTR_W'(DOUT_W);

    generate
        if ((DOUT_W % 2) != 0 || DOUT_W < 2) begin : g_bad_dout_w
            $error("ofdm_bit_packer: DOUT_W must be even and at least 2");
        end
        if (NBINS < 2 || NBINS > 4096) begin : g_bad_nbins
            $error("ofdm_bit_packer: NBINS must lie in 2..4096");
        end
    endgenerate

    // ------------------------------------------------------------------ state
    state_e              r_state;
    mode_e               r_mode;
    logic [BIN_W-1:0]    r_bin_cnt;
    logic [PTR_W-1:0]    r_bit_ptr;
    logic [DOUT_W-1:0]   r_shift;
    logic                r_push_out;
    logic [DOUT_W-1:0]   r_data_out;
    logic                r_last_out;
    logic                r_sym_err;
    logic [15:0]         r_sym_count;

    state_e              w_state_nxt;
    mode_e               w_mode_nxt;
    logic [BIN_W-1:0]    w_bin_nxt;
    logic [PTR_W-1:0]    w_ptr_nxt;
    logic [DOUT_W-1:0]   w_shift_nxt;
    logic                w_push_nxt;
    logic [DOUT_W-1:0]   w_data_nxt;
    logic                w_last_nxt;
    logic                w_err_nxt;
    logic [15:0]         w_cnt_nxt;

    // ------------------------------------------------------- current bin view
    logic                w_start;
    logic                w_accept;
    mode_e               w_slice_mode;
    logic [1:0]          w_bits;
    logic [1:0]          w_nbits;
    logic [BIN_W-1:0]    w_cur_bin;
    logic [PTR_W-1:0]    w_cur_ptr;
    logic [DOUT_W-1:0]   w_cur_shift;
    logic [DOUT_W-1:0]   w_word;
    logic [PTR_W-1:0]    w_ptr_sum;

    assign w_start  = Pushin & FirstData;
    assign w_accept = Pushin & (FirstData | (r_state == ST_COLLECT));

    // A FirstData bin is sliced with the fresh Mode; later bins use the
    // latched one so mid-symbol Mode changes have no effect.
    assign w_slice_mode = w_start ? mode_e'(Mode) : r_mode;

    // A FirstData bin restarts from an empty word, discarding any partial
    // word of an aborted symbol.
    assign w_cur_bin   = w_start ? '0 : r_bin_cnt;
    assign w_cur_ptr   = w_start ? '0 : r_bit_ptr;
    assign w_cur_shift = w_start ? '0 : r_shift;

    // The pointer advances by 1 or 2 from 0 and DOUT_W is even, so in QPSK it
    // is always even and a bin's two bits always fit in the current word.
    assign w_word    = w_cur_shift | (DOUT_W'(w_bits) << w_cur_ptr);
    assign w_ptr_sum = w_cur_ptr + PTR_W'(w_nbits);

    ofdm_slicer #(
        .DIN_W (DIN_W)
    ) u_slicer (
        .i_din_r (DinR),
        .i_din_i (DinI),
        .i_mode  (w_slice_mode),
        .o_bits  (w_bits),
        .o_nbits (w_nbits)
    );

    // ------------------------------------------------ next-state and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_bin_nxt   = r_bin_cnt;
        w_ptr_nxt   = r_bit_ptr;
        w_shift_nxt = r_shift;
        w_push_nxt  = 1'b0;
        w_data_nxt  = r_data_out;
        w_last_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_sym_count;

        // Framing errors: a stray bin while idle, or a restart mid-symbol.
        if (Pushin && !FirstData && r_state == ST_IDLE) begin
            w_err_nxt = 1'b1;
        end
        if (w_start && r_state == ST_COLLECT) begin
            w_err_nxt = 1'b1;
        end

        if (w_accept) begin
            if (w_start) begin
                w_mode_nxt  = mode_e'(Mode);
                w_state_nxt = ST_COLLECT;
            end

            if (w_cur_bin == LAST_BIN) begin
                // Final bin: flush whatever is there, full or partial.
                w_push_nxt  = 1'b1;
                w_data_nxt  = w_word;
                w_last_nxt  = 1'b1;
                w_cnt_nxt   = r_sym_count + 16'd1;
                w_state_nxt = ST_IDLE;
                w_bin_nxt   = '0;
                w_ptr_nxt   = '0;
                w_shift_nxt = '0;
            end else begin
                w_bin_nxt = w_cur_bin + BIN_W'(1);
                if (w_ptr_sum == FULL_PTR) begin
                    w_push_nxt  = 1'b1;
                    w_data_nxt  = w_word;
                    w_ptr_nxt   = '0;
                    w_shift_nxt = '0;
                end else begin
                    w_ptr_nxt   = w_ptr_sum;
                    w_shift_nxt = w_word;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_BPSK;
            r_bin_cnt   <= '0;
            r_bit_ptr   <= '0;
            r_shift     <= '0;
            r_push_out  <= 1'b0;
            r_data_out  <= '0;
            r_last_out  <= 1'b0;
            r_sym_err   <= 1'b0;
            r_sym_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_bin_cnt   <= w_bin_nxt;
            r_bit_ptr   <= w_ptr_nxt;
            r_shift     <= w_shift_nxt;
            r_push_out  <= w_push_nxt;
            r_data_out  <= w_data_nxt;
            r_last_out  <= w_last_nxt;
            r_sym_err   <= w_err_nxt;
            r_sym_count <= w_cnt_nxt;
        end
    end

    assign PushOut  = r_push_out;
    assign DataOut  = r_data_out;
    assign LastOut  = r_last_out;
    assign SymErr   = r_sym_err;
    assign SymCount = r_sym_count;

endmodule : ofdm_bit_packer
